proc_run_controller: RTL and testbench
======================================

Name: proc_run_controller

Overview:
- Sequences execution of the MIPS core on the FPGA board.
- Produces a one-cycle clock-enable pulse (`proc_ce`) for the processor from the board clock.
- Supports three modes: free-run, debounced single-step, and halt on end of instruction memory. Also provides an executed-instruction counter and completion LEDs.
- Sits between the board switches/buttons and the processor/data-memory enable inputs, alongside the seven-segment display path.

Parameters:
- DIV_COUNT, 15000: board clocks per processor tick, valid range ≥ 2.
- DEBOUNCE_CYCLES, 16: clocks the synchronised step button must be stable before it is accepted, valid range ≥ 1.
- CNT_W, 32: width of the instruction counter.

Ports:
- clk  in  1  board clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level switch; 1 requests free-run.
- step_btn  in  1  raw push button; asynchronous to clk.
- mem_end  in  1  instruction memory past its last word.
- pc  in  32  current processor PC (byte address).
- bp_addr  in  32  breakpoint PC.
- bp_en  in  1  breakpoint armed.
- proc_ce  out  1  one-clk enable pulse to the processor and data memory.
- state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 HALT.
- instr_count  out  CNT_W  number of proc_ce pulses issued.
- bp_hit  out  1  sticky breakpoint flag.
- completed  out  1  registered copy of HALT state.
- not_completed  out  1  registered inverse of `completed`.

Behaviour:
- Reset (reset=0, async): divider=0, state=IDLE, proc_ce=0, instr_count=0, bp_hit=0, completed=0, not_completed=1, debounce state cleared.
- Divider: counts 0..DIV_COUNT-1 and wraps. `tick` is high for one clk when divider==DIV_COUNT-1. The divider free-runs in all states.
- Step input:
  - 2-FF synchroniser.
  - Debounce counter loads 0 whenever the synchronised value changes. The value is accepted once it is unchanged for DEBOUNCE_CYCLES clocks.
  - `step_pulse` is one clk wide on the accepted 0→1 edge only. Holding the button gives one pulse.
- Next-state priority, evaluated every clk, highest first:
  1. mem_end=1 in any non-HALT state → HALT. proc_ce stays 0 that cycle.
  2. IDLE: run=1 → RUN; else step_pulse → STEP; else stay.
  3. RUN: run=0 → IDLE. On tick: proc_ce=1 and stay RUN (breakpoint case under Optional Feature).
  4. STEP: on tick, proc_ce=1 → IDLE. A step_pulse arriving while already in STEP is dropped.
  5. HALT: absorbing; leaves only via reset.
- proc_ce:
  - Registered, high for exactly one clk.
  - Asserted only in RUN or STEP, on the clk after tick.
  - Step latency: 1 to DIV_COUNT clks after step_pulse.
- instr_count: +1 per proc_ce; saturates at all-ones.
- completed / not_completed: registered from (state==HALT), one clk latency.
- run toggled mid-tick: RUN→IDLE takes effect immediately, so no partial pulse is issued.

Optional Feature:
- Macro: PROC_RUN_BREAKPOINT_EN.
- Defined:
  - In RUN, on tick with bp_en=1 and pc==bp_addr: no proc_ce, state → IDLE, bp_hit=1.
  - bp_hit clears on the next accepted step_pulse or on run 0→1.
  - A STEP issued at the breakpoint PC always executes, so the core can step past it.
- Undefined: pc/bp_addr/bp_en are ignored and bp_hit is tied 0. The ports remain so that the board top-level is unchanged.

Decomposition:
- Shared package/defines file holds the state encodings (ST_IDLE, ST_RUN, ST_STEP, ST_HALT) and the default DIV_COUNT, so the display controller can decode `state`.
- One sub-module is natural: btn_debounce (synchroniser, stability counter, rising-edge pulse). It is reusable for the memory-pointer increment/decrement buttons.

Test Plan:
(All scenarios use DIV_COUNT=4 and DEBOUNCE_CYCLES=3.)
- Reset behaviour: assert reset=0 mid-RUN → all outputs at reset values asynchronously; after release, first proc_ce appears no earlier than 4 clks after run=1.
- Free-run: run=1 for 40 clks → 10 proc_ce pulses, each 1 clk wide and spaced 4 apart; instr_count=10; run=0 → state=IDLE with no further pulses.
- Step debounce: step_btn bouncing 1,0,1,0 at 1-clk intervals, then held 1 for 20 clks → exactly one proc_ce, instr_count +1, state STEP→IDLE. A second press gives exactly one more pulse.
- Halt on memory end: mem_end=1 in RUN → state=HALT next clk, no proc_ce; completed=1 and not_completed=0 one clk later; run and step are then ignored until reset.
- Counter saturation: with CNT_W=4, issue 20 steps → instr_count stays at 15.
- Breakpoint (macro defined): bp_en=1, bp_addr=0x0C, pc advancing 0,4,8,0x0C → pulses stop with pc=0x0C, state=IDLE, bp_hit=1; one step → proc_ce issued, bp_hit=0.

Source files
------------

// File: rtl/proc_run_controller_pkg.sv
// Shared definitions for the processor run controller: state encodings
// (also decoded by the seven-segment display path) and default parameters.
package proc_run_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } run_state_e;

    localparam int DEFAULT_DIV_COUNT       = 15000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_CNT_W           = 32;

endpackage

// File: rtl/proc_run_controller_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-clock pulse on the accepted rising edge. Reusable for any board button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          last_q, last_d;
    logic          stable_q, stable_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronise, track stability and accept a value once it held long enough
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        last_d   = sync2_q;
        stable_d = stable_q;
        pulse_d  = 1'b0;
        if (sync2_q != last_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // last_q has now been unchanged for DEBOUNCE_CYCLES clocks
        if ((cnt_q == CNT_MAX) && (last_q != stable_q)) begin
            stable_d = last_q;
            pulse_d  = last_q;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            last_q   <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            last_q   <= last_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/proc_run_controller.sv
// Processor run controller: divides the board clock into a one-clock
// processor enable and sequences free-run, single-step and halt-at-end.
// Optional breakpoint support is built when PROC_RUN_BREAKPOINT_EN is defined;
// otherwise pc/bp_addr/bp_en are ignored and bp_hit is tied low.
module proc_run_controller
    import proc_run_controller_pkg::*;
#(
    parameter int DIV_COUNT       = DEFAULT_DIV_COUNT,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step_btn,
    input  logic             mem_end,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_en,
    output logic             proc_ce,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             bp_hit,
    output logic             completed,
    output logic             not_completed
);

    localparam int DW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);

    logic [DW-1:0]    div_q, div_d;
    logic             tick;
    run_state_e       state_q, state_d;
    logic             proc_ce_q, proc_ce_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             completed_q, completed_d;
    logic             not_completed_q, not_completed_d;
    logic             bp_hit_q, bp_hit_d;
    logic             step_pulse;
    logic             bp_match;
    logic             run_allowed;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk    (clk),
        .rst_n  (reset),
        .btn_raw(step_btn),
        .pulse  (step_pulse)
    );

    assign tick = (div_q == DIV_LAST);

`ifdef PROC_RUN_BREAKPOINT_EN
    logic run_prev_q, run_prev_d;
    logic run_rise;

    assign run_prev_d  = run;
    assign run_rise    = run & ~run_prev_q;
    assign bp_match    = bp_en & (pc == bp_addr);
    // After a breakpoint stop, only a fresh run request may resume free-run
    assign run_allowed = ~bp_hit_q | run_rise;

    // Previous run level for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) run_prev_q <= 1'b0;
        else        run_prev_q <= run_prev_d;
    end
`else
    logic unused_bp_inputs;

    assign unused_bp_inputs = ^{pc, bp_addr, bp_en};
    assign bp_match         = 1'b0;
    assign run_allowed      = 1'b1;
`endif

    // Next-state selection, mem_end has top priority
    always_comb begin
        state_d = state_q;
        if (mem_end && (state_q != ST_HALT)) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run && run_allowed) state_d = ST_RUN;
                    else if (step_pulse)    state_d = ST_STEP;
                end
                ST_RUN: begin
                    if (!run)                 state_d = ST_IDLE;
                    else if (tick && bp_match) state_d = ST_IDLE;
                end
                ST_STEP: begin
                    if (tick) state_d = ST_IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Enable pulse, instruction counter, breakpoint flag and completion LEDs
    always_comb begin
        div_d     = tick ? '0 : div_q + DW'(1);
        proc_ce_d = 1'b0;
        if (!mem_end) begin
            case (state_q)
                ST_RUN:  proc_ce_d = run & tick & ~bp_match;
                ST_STEP: proc_ce_d = tick;
                default: proc_ce_d = 1'b0;
            endcase
        end
        cnt_d = cnt_q;
        if (proc_ce_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
        completed_d     = (state_q == ST_HALT);
        not_completed_d = ~completed_d;
`ifdef PROC_RUN_BREAKPOINT_EN
        bp_hit_d = bp_hit_q;
        if (!mem_end && (state_q == ST_RUN) && run && tick && bp_match) bp_hit_d = 1'b1;
        else if (step_pulse || run_rise)                               bp_hit_d = 1'b0;
`else
        bp_hit_d = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q           <= '0;
            state_q         <= ST_IDLE;
            proc_ce_q       <= 1'b0;
            cnt_q           <= '0;
            completed_q     <= 1'b0;
            not_completed_q <= 1'b1;
            bp_hit_q        <= 1'b0;
        end else begin
            div_q           <= div_d;
            state_q         <= state_d;
            proc_ce_q       <= proc_ce_d;
            cnt_q           <= cnt_d;
            completed_q     <= completed_d;
            not_completed_q <= not_completed_d;
            bp_hit_q        <= bp_hit_d;
        end
    end

    assign proc_ce       = proc_ce_q;
    assign state         = state_q;
    assign instr_count   = cnt_q;
    assign bp_hit        = bp_hit_q;
    assign completed     = completed_q;
    assign not_completed = not_completed_q;

endmodule

// File: tb/tb_proc_run_controller.sv
// Bench for proc_run_controller with DIV_COUNT=4, DEBOUNCE_CYCLES=3, CNT_W=4.
// Expected instr_count values are queued when stimulus is applied and checked
// as each proc_ce pulse is observed.
`timescale 1ns/1ps
module tb_proc_run_controller;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int CW  = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STEP = 2'b10;
    localparam logic [1:0] S_HALT = 2'b11;

    logic          clk = 1'b0;
    logic          reset, run, step_btn, mem_end, bp_en;
    logic [31:0]   pc, bp_addr;
    logic          proc_ce, bp_hit, completed, not_completed;
    logic [1:0]    state;
    logic [CW-1:0] instr_count;

    int            total = 0;
    int            bad = 0;
    int            pulses = 0;
    int            cyc = 0;
    int            last_pulse_cyc = -1;
    int            model_cnt = 0;
    bit            check_spacing = 1'b0;
    logic          prev_ce = 1'b0;
    logic [CW-1:0] exp_v;
    logic [CW-1:0] exp_q[$];

    always #5 clk = ~clk;

    proc_run_controller #(
        .DIV_COUNT      (DIV),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .step_btn     (step_btn),
        .mem_end      (mem_end),
        .pc           (pc),
        .bp_addr      (bp_addr),
        .bp_en        (bp_en),
        .proc_ce      (proc_ce),
        .state        (state),
        .instr_count  (instr_count),
        .bp_hit       (bp_hit),
        .completed    (completed),
        .not_completed(not_completed)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: pops the scoreboard on every proc_ce
    always @(negedge clk) begin
        if (proc_ce === 1'b1) begin
            pulses = pulses + 1;
            total  = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_pulse: got pulse with count=%0d at cycle %0d, none expected", instr_count, cyc);
            end else begin
                exp_v = exp_q.pop_front();
                if (instr_count !== exp_v) begin
                    bad = bad + 1;
                    $display("FAIL pulse_count: instr_count=%0d expected=%0d", instr_count, exp_v);
                end
            end
            total = total + 1;
            if (prev_ce === 1'b1) begin
                bad = bad + 1;
                $display("FAIL pulse_width: proc_ce high on two consecutive clocks at cycle %0d", cyc);
            end
            if (check_spacing && last_pulse_cyc >= 0) begin
                total = total + 1;
                if (cyc - last_pulse_cyc != DIV) begin
                    bad = bad + 1;
                    $display("FAIL pulse_spacing: spacing=%0d expected=%0d", cyc - last_pulse_cyc, DIV);
                end
            end
            last_pulse_cyc = cyc;
        end
        prev_ce = proc_ce;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_expected();
        if (model_cnt < 15) model_cnt = model_cnt + 1;
        exp_q.push_back(model_cnt[CW-1:0]);
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        int i = 0;
        while (pulses < n && i < budget) begin
            step_clk(1);
            i++;
        end
        total++;
        if (pulses < n) begin
            bad++;
            $display("FAIL %s_timeout: pulses=%0d required=%0d within %0d clks", name, pulses, n, budget);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0; run = 1'b0; step_btn = 1'b0; mem_end = 1'b0;
        bp_en = 1'b0; pc = 32'd0; bp_addr = 32'd0;
        exp_q.delete();
        model_cnt = 0; pulses = 0; check_spacing = 1'b0; last_pulse_cyc = -1;
        step_clk(2);
        reset = 1'b1;
        step_clk(1);
    endtask

    task automatic press_step(input int hold, input int rel);
        step_btn = 1'b1;
        step_clk(hold);
        step_btn = 1'b0;
        step_clk(rel);
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if ({state, proc_ce, instr_count, bp_hit, completed, not_completed} !==
            {S_IDLE, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL %s: state=%b ce=%b cnt=%0d bp=%b comp=%b ncomp=%b required 00/0/0/0/0/1",
                     name, state, proc_ce, instr_count, bp_hit, completed, not_completed);
        end
    endtask

    task automatic test_reset();
        int c0;
        reset = 1'b0; run = 1'b0; step_btn = 1'b0; mem_end = 1'b0;
        bp_en = 1'b0; pc = 32'd0; bp_addr = 32'd0;
        step_clk(2);
        check_reset_values("reset_initial");
        reset = 1'b1;
        run   = 1'b1;
        push_expected();
        push_expected();
        wait_pulses(2, 20, "reset_run");
        total++;
        if (state !== S_RUN) begin
            bad++;
            $display("FAIL reset_pre_state: state=%b required=%b", state, S_RUN);
        end
        // Reset asserted between clock edges must act immediately
        #1 reset = 1'b0;
        #1;
        check_reset_values("reset_async");
        exp_q.delete();
        pulses = 0; model_cnt = 0;
        step_clk(1);
        check_reset_values("reset_held");
        reset = 1'b1;
        c0 = cyc;
        push_expected();
        wait_pulses(1, 12, "reset_first_pulse");
        total++;
        if (last_pulse_cyc - c0 < DIV || last_pulse_cyc - c0 > DIV + 1) begin
            bad++;
            $display("FAIL reset_first_latency: latency=%0d required %0d..%0d", last_pulse_cyc - c0, DIV, DIV + 1);
        end
        run = 1'b0;
        step_clk(3);
    endtask

    task automatic test_free_run();
        apply_reset();
        check_spacing = 1'b1;
        last_pulse_cyc = -1;
        for (int i = 0; i < 10; i++) push_expected();
        run = 1'b1;
        wait_pulses(10, 60, "free_run");
        total++;
        if (instr_count !== 4'd10) begin
            bad++;
            $display("FAIL free_run_count: instr_count=%0d required=10", instr_count);
        end
        run = 1'b0;
        check_spacing = 1'b0;
        step_clk(1);
        total++;
        if (state !== S_IDLE) begin
            bad++;
            $display("FAIL free_run_stop_state: state=%b required=%b", state, S_IDLE);
        end
        step_clk(12);
        total++;
        if (pulses !== 10) begin
            bad++;
            $display("FAIL free_run_after_stop: pulses=%0d required=10", pulses);
        end
    endtask

    task automatic test_step_debounce();
        int p0;
        bit seen_step;
        logic [3:0] pat;
        pat = 4'b1010;
        p0 = pulses;
        seen_step = 1'b0;
        push_expected();
        for (int i = 3; i >= 0; i--) begin
            step_btn = pat[i];
            step_clk(1);
        end
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step_clk(1);
            if (state === S_STEP) seen_step = 1'b1;
        end
        step_btn = 1'b0;
        step_clk(10);
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL step_single_pulse: pulses=%0d required=1", pulses - p0);
        end
        total++;
        if (!seen_step) begin
            bad++;
            $display("FAIL step_state_seen: STEP state observed=%b required=1", seen_step);
        end
        total++;
        if (state !== S_IDLE) begin
            bad++;
            $display("FAIL step_return_idle: state=%b required=%b", state, S_IDLE);
        end
        push_expected();
        press_step(20, 10);
        total++;
        if (pulses - p0 !== 2) begin
            bad++;
            $display("FAIL step_second_press: pulses=%0d required=2", pulses - p0);
        end
        total++;
        if (instr_count !== model_cnt[CW-1:0]) begin
            bad++;
            $display("FAIL step_count: instr_count=%0d required=%0d", instr_count, model_cnt);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        push_expected();
        push_expected();
        run = 1'b1;
        wait_pulses(2, 20, "halt_run");
        step_clk(2);
        mem_end = 1'b1;
        step_clk(1);
        total++;
        if (state !== S_HALT || proc_ce !== 1'b0) begin
            bad++;
            $display("FAIL halt_entry: state=%b ce=%b required state=%b ce=0", state, proc_ce, S_HALT);
        end
        total++;
        if (completed !== 1'b0 || not_completed !== 1'b1) begin
            bad++;
            $display("FAIL halt_led_latency: completed=%b not_completed=%b required 0/1", completed, not_completed);
        end
        step_clk(1);
        total++;
        if (completed !== 1'b1 || not_completed !== 1'b0) begin
            bad++;
            $display("FAIL halt_leds: completed=%b not_completed=%b required 1/0", completed, not_completed);
        end
        mem_end = 1'b0;
        run = 1'b0;
        step_clk(2);
        run = 1'b1;
        press_step(15, 10);
        run = 1'b0;
        step_clk(5);
        total++;
        if (state !== S_HALT || pulses !== 2 || instr_count !== 4'd2) begin
            bad++;
            $display("FAIL halt_absorbing: state=%b pulses=%0d cnt=%0d required %b/2/2", state, pulses, instr_count, S_HALT);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            push_expected();
            press_step(10, 8);
        end
        total++;
        if (pulses !== 20) begin
            bad++;
            $display("FAIL sat_pulses: pulses=%0d required=20", pulses);
        end
        total++;
        if (instr_count !== 4'd15) begin
            bad++;
            $display("FAIL sat_count: instr_count=%0d required=15", instr_count);
        end
    endtask

    task automatic test_breakpoint();
        apply_reset();
`ifdef PROC_RUN_BREAKPOINT_EN
        bp_en = 1'b1;
        bp_addr = 32'h0000_000C;
        pc = 32'd0;
        for (int i = 0; i < 3; i++) push_expected();
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step_clk(1);
            if (proc_ce === 1'b1) pc = pc + 32'd4;
        end
        total++;
        if (pulses !== 3 || state !== S_IDLE || bp_hit !== 1'b1) begin
            bad++;
            $display("FAIL bp_stop: pulses=%0d state=%b bp_hit=%b required 3/%b/1", pulses, state, bp_hit, S_IDLE);
        end
        run = 1'b0;
        push_expected();
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) step_btn = 1'b0;
            step_clk(1);
            if (proc_ce === 1'b1) pc = pc + 32'd4;
        end
        total++;
        if (pulses !== 4 || bp_hit !== 1'b0 || instr_count !== 4'd4) begin
            bad++;
            $display("FAIL bp_step_past: pulses=%0d bp_hit=%b cnt=%0d required 4/0/4", pulses, bp_hit, instr_count);
        end
`else
        bp_en = 1'b1;
        bp_addr = 32'd0;
        pc = 32'd0;
        for (int i = 0; i < 3; i++) push_expected();
        run = 1'b1;
        wait_pulses(3, 20, "bp_ignored");
        total++;
        if (bp_hit !== 1'b0 || state !== S_RUN) begin
            bad++;
            $display("FAIL bp_ignored: bp_hit=%b state=%b required 0/%b", bp_hit, state, S_RUN);
        end
        run = 1'b0;
        step_clk(3);
`endif
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_step_debounce();
        test_halt();
        test_saturation();
        test_breakpoint();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
